// File: rtl/fuse_loader.sv
// ---------------------------------------------------------------------------
// fuse_loader
//
// Serial loader for the routing-mux fuse register of the CPLD model.
// A frame has NFUSE data bits, LSB (fuse 0) first, followed by one even-parity
// bit. fuse_q is updated in a single edge, and only when the parity check
// passes, so the mux selects never see a partial frame. While the data bits
// come in, the previously committed fuses go out on o_sdo, LSB first, which
// gives a readback path.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous reset, active low
//   i_start      begin a frame (only looked at in IDLE)
//   i_abort      drop the current frame without committing
//   i_sdi        serial data in, LSB first
//   i_sdi_valid  i_sdi is taken only on cycles where this is 1
//   o_sdo        serial readback of the old fuse_q, LSB first
//   o_busy       high in SHIFT and PARITY
//   o_done       one-cycle pulse: frame committed
//   o_err        one-cycle pulse: parity mismatch, frame discarded
//   o_fuse_q     committed fuse bits (mux select lines)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; o_sdo low
// SHIFT  | taking data bits; o_sdo shows the old fuse bit at the LSB
// PARITY | waiting for the parity bit; commit on pass, drop on fail
// ---------------------------------------------------------------------------
module fuse_loader #(
    parameter int               NFUSE     = 16,
    parameter logic [NFUSE-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_sdi,
    input  logic             i_sdi_valid,
    output logic             o_sdo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [NFUSE-1:0] o_fuse_q
);

    localparam int             CW   = $clog2(NFUSE + 1);
    localparam logic [CW-1:0]  LAST = CW'(NFUSE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t           r_state;
    logic [NFUSE-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_par;
    logic [NFUSE-1:0] r_fuse;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [NFUSE-1:0] w_shift_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_par_nxt;
    logic [NFUSE-1:0] w_fuse_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_par   <= 1'b0;
            r_fuse  <= RESET_VAL;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_par   <= w_par_nxt;
            r_fuse  <= w_fuse_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_par_nxt   = r_par;
        w_fuse_nxt  = r_fuse;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Preloading the shift register with fuse_q is what makes the
                // readback work: old bits fall out of the LSB as new ones
                // enter at the MSB.
                if (i_start && !i_abort) begin
                    w_shift_nxt = r_fuse;
                    w_count_nxt = '0;
                    w_par_nxt   = 1'b0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_sdi_valid) begin
                    w_shift_nxt = {i_sdi, r_shift[NFUSE-1:1]};
                    w_par_nxt   = r_par ^ i_sdi;
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == LAST) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_sdi_valid) begin
                    if ((r_par ^ i_sdi) == 1'b0) begin
                        w_fuse_nxt = r_shift;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_sdo    = (r_state == S_SHIFT) ? r_shift[0] : 1'b0;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_fuse_q = r_fuse;

endmodule

// File: tb/tb_fuse_loader.sv
module tb_fuse_loader;

    localparam int         NF = 8;
    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sdi = 1'b0;
    logic       sdi_valid = 1'b0;
    logic       sdo;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] fuse_q;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_fuse;
    logic       sdo_q[$];
    logic [9:0] res_q[$];

    fuse_loader #(.NFUSE(NF), .RESET_VAL(RV)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_sdi       (sdi),
        .i_sdi_valid (sdi_valid),
        .o_sdo       (sdo),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_fuse_q    (fuse_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_sdo_exp;
        for (int i = 0; i < NF; i++) sdo_q.push_back(m_fuse[i]);
    endtask

    task automatic chk_sdo;
        logic e;
        if (sdo_q.size() == 0) begin
            chk("sdo_queue_empty", 32'd1, 32'd0);
        end else begin
            e = sdo_q.pop_front();
            chk("sdo_shift", sdo, e);
        end
    endtask

    // Runs one full frame; returns in the cycle where done/err should be high.
    task automatic run_frame(input logic [7:0] data, input logic pbit, input int gap);
        logic [9:0] r;
        logic       good;
        start = 1'b1;
        push_sdo_exp();
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < NF; i++) begin
            for (int g = 0; g < gap; g++) begin
                sdi_valid = 1'b0;
                sdi = ~data[i];
                tick;
                chk("busy_gap", busy, 1);
            end
            sdi = data[i];
            sdi_valid = 1'b1;
            chk_sdo();
            chk("fuse_stable", fuse_q, m_fuse);
            tick;
        end
        sdi = pbit;
        sdi_valid = 1'b1;
        chk("sdo_parity", sdo, 0);
        chk("busy_parity", busy, 1);
        good = (((^data) ^ pbit) == 1'b0);
        res_q.push_back({good, ~good, good ? data : m_fuse});
        if (good) m_fuse = data;
        tick;
        sdi_valid = 1'b0;
        sdi = 1'b0;
        if (res_q.size() == 0) begin
            chk("res_queue_empty", 32'd1, 32'd0);
        end else begin
            r = res_q.pop_front();
            chk("done", done, r[9]);
            chk("err", err, r[8]);
            chk("fuse_q", fuse_q, r[7:0]);
        end
        chk("busy_end", busy, 0);
    endtask

    task automatic quiet_tick;
        tick;
        chk("done_single", done, 0);
        chk("err_single", err, 0);
    endtask

    initial begin
        // 1: reset values
        #12;
        chk("rst_fuse", fuse_q, RV);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sdo", sdo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        m_fuse = RV;

        // 2: A5 with good parity, readback of 3C
        run_frame(8'hA5, 1'b0, 0);
        quiet_tick();

        // reset mid-frame: fuse_q reverts to RESET_VAL without a clock edge
        start = 1'b1;
        tick;
        start = 1'b0;
        sdi_valid = 1'b1;
        sdi = 1'b1;
        tick;
        tick;
        tick;
        sdi_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_fuse", fuse_q, RV);
        chk("midrst_busy", busy, 0);
        chk("midrst_sdo", sdo, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        sdo_q.delete();
        m_fuse = RV;
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // 3: bad parity
        run_frame(8'hA5, 1'b1, 0);
        quiet_tick();
        chk("err_fuse_kept", fuse_q, RV);

        // 4: gapped valid
        run_frame(8'hFF, 1'b0, 2);
        quiet_tick();

        // 5: abort after 5 bits, ignored start in SHIFT, start+abort in IDLE
        start = 1'b1;
        push_sdo_exp();
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                sdi_valid = 1'b0;
                start = 1'b1;
                tick;
                start = 1'b0;
                chk("busy_start_ignored", busy, 1);
            end
            sdi = i[0];
            sdi_valid = 1'b1;
            chk_sdo();
            tick;
        end
        abort = 1'b1;
        sdi = 1'b1;
        sdi_valid = 1'b1;
        tick;
        abort = 1'b0;
        sdi_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_fuse", fuse_q, m_fuse);
        sdo_q.delete();
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy", busy, 0);
        tick;
        chk("startabort_busy2", busy, 0);
        chk("startabort_fuse", fuse_q, m_fuse);
        run_frame(8'h5A, 1'b0, 0);
        quiet_tick();

        // 6: back-to-back, second start in the done cycle
        run_frame(8'h01, 1'b1, 0);
        run_frame(8'h80, 1'b1, 0);
        quiet_tick();
        chk("final_fuse", fuse_q, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
